maq_bcd: RTL

Parametrised two-digit BCD modulo counter for the digital-clock datapath; generalises the fixed mod-60 minutes stage. One instance per time field (seconds/minutes mod 60, hours mod 24 or 12), cascaded through carry/borrow pulses. Adds down-counting, synchronous load for time setting with validity checking, and a terminal-count flag for synchronous cascading.

---
 rtl/maq_bcd_if.sv | 32 +++
 rtl/maq_bcd.sv | 118 +++++++++++
 2 files changed

// File: rtl/maq_bcd_if.sv
// maq_bcd_if: count-control, load and result bundle for one maq_bcd time field.
// The slave modport is the counter side; the master modport drives ticks and loads.
interface maq_bcd_if #(
  parameter int MSD_W = 3
);
  logic             maqbcd_enable;
  logic             maqbcd_incremento;
  logic             maqbcd_down;
  logic             maqbcd_load;
  logic [3:0]       maqbcd_load_lsd;
  logic [MSD_W-1:0] maqbcd_load_msd;
  logic [3:0]       maqbcd_Lsd;
  logic [MSD_W-1:0] maqbcd_Msd;
  logic             maqbcd_carry;
  logic             maqbcd_borrow;
  logic             maqbcd_tc;
  logic             maqbcd_load_err;

  modport slave (
    input  maqbcd_enable, maqbcd_incremento, maqbcd_down, maqbcd_load,
           maqbcd_load_lsd, maqbcd_load_msd,
    output maqbcd_Lsd, maqbcd_Msd, maqbcd_carry, maqbcd_borrow,
           maqbcd_tc, maqbcd_load_err
  );

  modport master (
    output maqbcd_enable, maqbcd_incremento, maqbcd_down, maqbcd_load,
           maqbcd_load_lsd, maqbcd_load_msd,
    input  maqbcd_Lsd, maqbcd_Msd, maqbcd_carry, maqbcd_borrow,
           maqbcd_tc, maqbcd_load_err
  );
endinterface

// File: rtl/maq_bcd.sv
// maq_bcd: two-digit BCD modulo-MODULUS up/down counter for one clock field.
// Digits are stepped per digit (no binary conversion), so only valid BCD
// values ever reach the registers. carry/borrow/load_err are one-cycle pulses
// aligned with the digits they describe; tc is the combinational look-ahead
// used for synchronous cascading.
module maq_bcd #(
  parameter int MODULUS = 60,
  parameter int MSD_W   = 3
) (
  input  logic      i_maqbcd_clock,
  input  logic      i_maqbcd_reset,
  maq_bcd_if.slave  io_maqbcd
);

  // Terminal value split into its BCD digits at elaboration time.
  localparam int               MAX_V   = MODULUS - 1;
  localparam logic [3:0]       MAX_LSD = 4'(MAX_V % 10);
  localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'(MAX_V / 10);
  localparam logic [MSD_W-1:0] MSD_ONE = MSD_W'(1'b1);
  localparam logic [MSD_W-1:0] MSD_ZERO = {MSD_W{1'b0}};

  logic [3:0]       r_lsd;
  logic [MSD_W-1:0] r_msd;
  logic             r_carry;
  logic             r_borrow;
  logic             r_load_err;

  logic [3:0]       w_lsd_nxt;
  logic [MSD_W-1:0] w_msd_nxt;
  logic             w_carry_nxt;
  logic             w_borrow_nxt;
  logic             w_load_err_nxt;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tick;
  logic             w_load_ok;

  assign w_at_max  = (r_msd == MAX_MSD) && (r_lsd == MAX_LSD);
  assign w_at_zero = (r_msd == MSD_ZERO) && (r_lsd == 4'd0);
  assign w_tick    = io_maqbcd.maqbcd_enable && io_maqbcd.maqbcd_incremento;

  // A load is legal when the units digit is BCD and the two-digit value does
  // not exceed MODULUS-1; compared digit-wise so no multiplier is needed.
  assign w_load_ok = (io_maqbcd.maqbcd_load_lsd <= 4'd9) &&
                     ((io_maqbcd.maqbcd_load_msd < MAX_MSD) ||
                      ((io_maqbcd.maqbcd_load_msd == MAX_MSD) &&
                       (io_maqbcd.maqbcd_load_lsd <= MAX_LSD)));

  // Next-state selection: load beats count, count beats hold; pulses default low.
  always_comb begin
    w_lsd_nxt      = r_lsd;
    w_msd_nxt      = r_msd;
    w_carry_nxt    = 1'b0;
    w_borrow_nxt   = 1'b0;
    w_load_err_nxt = 1'b0;
    if (io_maqbcd.maqbcd_load) begin
      if (w_load_ok) begin
        w_lsd_nxt = io_maqbcd.maqbcd_load_lsd;
        w_msd_nxt = io_maqbcd.maqbcd_load_msd;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (w_tick) begin
      if (!io_maqbcd.maqbcd_down) begin
        if (w_at_max) begin
          w_lsd_nxt   = 4'd0;
          w_msd_nxt   = MSD_ZERO;
          w_carry_nxt = 1'b1;
        end else if (r_lsd == 4'd9) begin
          w_lsd_nxt = 4'd0;
          w_msd_nxt = r_msd + MSD_ONE;
        end else begin
          w_lsd_nxt = r_lsd + 4'd1;
        end
      end else begin
        if (w_at_zero) begin
          w_lsd_nxt    = MAX_LSD;
          w_msd_nxt    = MAX_MSD;
          w_borrow_nxt = 1'b1;
        end else if (r_lsd == 4'd0) begin
          w_lsd_nxt = 4'd9;
          w_msd_nxt = r_msd - MSD_ONE;
        end else begin
          w_lsd_nxt = r_lsd - 4'd1;
        end
      end
    end else begin
      w_lsd_nxt = r_lsd;
      w_msd_nxt = r_msd;
    end
  end

  // State and pulse registers; asynchronous clear to 00 with pulses low.
  always_ff @(posedge i_maqbcd_clock or negedge i_maqbcd_reset) begin
    if (!i_maqbcd_reset) begin
      r_lsd      <= 4'd0;
      r_msd      <= MSD_ZERO;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_lsd      <= w_lsd_nxt;
      r_msd      <= w_msd_nxt;
      r_carry    <= w_carry_nxt;
      r_borrow   <= w_borrow_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign io_maqbcd.maqbcd_Lsd      = r_lsd;
  assign io_maqbcd.maqbcd_Msd      = r_msd;
  assign io_maqbcd.maqbcd_carry    = r_carry;
  assign io_maqbcd.maqbcd_borrow   = r_borrow;
  assign io_maqbcd.maqbcd_load_err = r_load_err;
  // Terminal count looks at the wrap point for the currently selected direction.
  assign io_maqbcd.maqbcd_tc       = io_maqbcd.maqbcd_down ? w_at_zero : w_at_max;

endmodule
